// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the pipeline-control handshake between the core datapath and the
// hazard/halt controller so that both sides see one named group of signals.
//
// Signals (direction as seen from the controller, i.e. the slave modport):
//   id_valid      in   ID holds a real instruction, not a bubble
//   id_rs1/rs2    in   source register addresses of the ID instruction
//   id_rs1_en/_en in   the matching source is actually read
//   id_rd         in   destination register of the ID instruction
//   id_rd_en      in   the ID instruction writes id_rd
//   id_halt       in   the ID instruction is HALT
//   exe_br_taken  in   EXE resolved a taken branch this cycle
//   wb_rd         in   register written back this cycle
//   wb_rd_en      in   writeback is active this cycle
//   stall_if      out  hold PC and IF_ID
//   bubble_id     out  ID_EXE loads a NOP
//   flush_if_id   out  IF_ID loads a NOP
//   halt          out  processor halted
//   busy          out  at least one register write is still in flight
//
// REG_ADDR_LEN must match the value used by the controller instance.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int REG_ADDR_LEN = 5
);

  logic                    id_valid;
  logic [REG_ADDR_LEN-1:0] id_rs1;
  logic [REG_ADDR_LEN-1:0] id_rs2;
  logic                    id_rs1_en;
  logic                    id_rs2_en;
  logic [REG_ADDR_LEN-1:0] id_rd;
  logic                    id_rd_en;
  logic                    id_halt;
  logic                    exe_br_taken;
  logic [REG_ADDR_LEN-1:0] wb_rd;
  logic                    wb_rd_en;
  logic                    stall_if;
  logic                    bubble_id;
  logic                    flush_if_id;
  logic                    halt;
  logic                    busy;

  // Datapath side: drives instruction/writeback information, reads controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en,
    output id_rd, id_rd_en, id_halt, exe_br_taken, wb_rd, wb_rd_en,
    input  stall_if, bubble_id, flush_if_id, halt, busy
  );

  // Controller side: consumes instruction/writeback information.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en,
    input  id_rd, id_rd_en, id_halt, exe_br_taken, wb_rd, wb_rd_en,
    output stall_if, bubble_id, flush_if_id, halt, busy
  );

endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Scoreboard-based hazard and halt controller for an in-order pipeline.
// Every architectural register has a 2-bit count of writes that have been
// issued but not yet written back. A reader of a pending register is held in
// ID (stall + bubble) until the count returns to zero; there is no bypass
// from WB. A taken branch in EXE flushes IF_ID and discards the ID
// instruction. HALT drains the back end for DRAIN_CYCLES plus however long
// outstanding writes take, then parks the block in HALTED until reset.
//
// Ports:
//   clk    in  single clock, all state changes on its rising edge
//   rst_n  in  asynchronous active-low reset
//   ctrl   pipe_ctrl_if.slave, see the interface file for the signal list
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave ctrl
);

  localparam int NUM_REGS = 1 << REG_ADDR_LEN;
  localparam int DRAIN_W  = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t             r_state;
  logic [DRAIN_W-1:0] r_drain;
  logic               r_halt;
  logic [1:0]         r_cnt [NUM_REGS];

  logic w_run;
  logic w_br;
  logic w_raw;
  logic w_stall;
  logic w_issue;
  logic w_inc;
  logic w_dec;
  logic w_busy;

  // A source only counts as a hazard if it is actually read, is not r0, and
  // has a write outstanding as of the previous edge. Writes landing in WB this
  // cycle do not clear the hazard until the counter has actually dropped.
  assign w_run = (r_state == RUN);
  assign w_raw = ctrl.id_valid &
                 ((ctrl.id_rs1_en & (ctrl.id_rs1 != '0) & (r_cnt[ctrl.id_rs1] != 2'd0)) |
                  (ctrl.id_rs2_en & (ctrl.id_rs2 != '0) & (r_cnt[ctrl.id_rs2] != 2'd0)));

  // The branch input feeds the outputs combinationally, so it is masked by
  // reset to keep every control output low while rst_n is held.
  assign w_br    = ctrl.exe_br_taken & rst_n;
  assign w_stall = w_run ? (w_raw & ~w_br) : 1'b1;
  assign w_issue = w_run & ctrl.id_valid & ~w_stall & ~w_br;

  // HALT never reserves its destination, and r0 is never tracked.
  assign w_inc = w_issue & ctrl.id_rd_en & ~ctrl.id_halt & (ctrl.id_rd != '0);
  assign w_dec = ctrl.wb_rd_en & (ctrl.wb_rd != '0);

  assign ctrl.stall_if    = w_stall;
  assign ctrl.bubble_id   = w_run ? (w_raw | w_br) : 1'b1;
  assign ctrl.flush_if_id = w_run & w_br;
  assign ctrl.halt        = r_halt;
  assign ctrl.busy        = w_busy;

  // busy is simply "any pending-write counter is non-zero", in every state.
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_busy = w_busy | (r_cnt[k] != 2'd0);
    end
  end

  // Per-register pending-write counters. An issue and a writeback to the
  // same register in one cycle cancel out. Overflow at 3 and underflow at 0
  // are protocol errors by the surrounding pipeline; the counter just
  // saturates rather than wrapping into a wrong value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_cnt[k] <= 2'd0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_inc && (ctrl.id_rd == REG_ADDR_LEN'(k)) &&
            !(w_dec && (ctrl.wb_rd == REG_ADDR_LEN'(k)))) begin
          if (r_cnt[k] != 2'd3) begin
            r_cnt[k] <= r_cnt[k] + 2'd1;
          end
        end else if (w_dec && (ctrl.wb_rd == REG_ADDR_LEN'(k)) &&
                     !(w_inc && (ctrl.id_rd == REG_ADDR_LEN'(k)))) begin
          if (r_cnt[k] != 2'd0) begin
            r_cnt[k] <= r_cnt[k] - 2'd1;
          end
        end
      end
    end
  end

  // Run/drain/halt sequencing. Issuing HALT arms the drain timer so EXE, MEM
  // and WB can empty; HALTED is entered only once the timer has expired and
  // no write is outstanding. Branches are ignored outside RUN, and HALTED is
  // left only through reset. halt is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_drain <= '0;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_issue && ctrl.id_halt) begin
            r_state <= DRAIN;
            r_drain <= DRAIN_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (r_drain != '0) begin
            r_drain <= r_drain - DRAIN_W'(1);
          end else if (!w_busy) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
          end
        end
        HALTED: begin
          r_halt <= 1'b1;
        end
        default: begin
          r_state <= RUN;
          r_drain <= '0;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. Each stimulus record carries the
// controls expected while it is applied; the expectation is queued when the
// record is driven and popped when the outputs are sampled mid-cycle. A
// shadow scoreboard of pending writes, fed only by the records, provides an
// independent busy check and flags protocol errors (overflow/underflow).
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int AW = 5;

  typedef struct {
    string          name;
    logic           valid;
    logic [AW-1:0]  rs1;
    logic           rs1En;
    logic [AW-1:0]  rs2;
    logic           rs2En;
    logic [AW-1:0]  rd;
    logic           rdEn;
    logic           isHalt;
    logic           br;
    logic [AW-1:0]  wbRd;
    logic           wbEn;
    logic [4:0]     expOut;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] out;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   shadow [1 << AW];
  exp_t expQ [$];
  vec_t tbl [20];

  pipe_ctrl_if #(.REG_ADDR_LEN(AW)) bus ();

  pipe_ctrl #(
    .REG_ADDR_LEN(AW),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against any hang so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Builds one record; expected outputs are {stall_if, bubble_id, flush_if_id, halt, busy}.
  function automatic vec_t mk(input string n, input logic v, input int r1, input logic r1e,
                              input int r2, input logic r2e, input int rd, input logic rde,
                              input logic h, input logic br, input int wb, input logic wbe,
                              input logic [4:0] e);
    vec_t t;
    t.name   = n;
    t.valid  = v;
    t.rs1    = AW'(r1);
    t.rs1En  = r1e;
    t.rs2    = AW'(r2);
    t.rs2En  = r2e;
    t.rd     = AW'(rd);
    t.rdEn   = rde;
    t.isHalt = h;
    t.br     = br;
    t.wbRd   = AW'(wb);
    t.wbEn   = wbe;
    t.expOut = e;
    return t;
  endfunction

  // Drives one record onto the interface and queues its expected outputs.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.id_valid     = v.valid;
    bus.id_rs1       = v.rs1;
    bus.id_rs1_en    = v.rs1En;
    bus.id_rs2       = v.rs2;
    bus.id_rs2_en    = v.rs2En;
    bus.id_rd        = v.rd;
    bus.id_rd_en     = v.rdEn;
    bus.id_halt      = v.isHalt;
    bus.exe_br_taken = v.br;
    bus.wb_rd        = v.wbRd;
    bus.wb_rd_en     = v.wbEn;
    e.name = v.name;
    e.out  = v.expOut;
    expQ.push_back(e);
  endtask

  // Pops the oldest expectation and compares it with the sampled outputs.
  task automatic checkOutput();
    exp_t       e;
    logic [4:0] act;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboardEmpty: no expectation queued");
      return;
    end
    e   = expQ.pop_front();
    act = {bus.stall_if, bus.bubble_id, bus.flush_if_id, bus.halt, bus.busy};
    if (act !== e.out) begin
      failures++;
      $display("[TB] FAIL %s: stall/bubble/flush/halt/busy got %b expected %b", e.name, act, e.out);
    end
  endtask

  // busy must agree with the shadow pending-write scoreboard.
  task automatic checkBusyModel(input string n);
    logic anyPending;
    anyPending = 1'b0;
    foreach (shadow[k]) begin
      if (shadow[k] != 0) anyPending = 1'b1;
    end
    checks++;
    if (bus.busy !== anyPending) begin
      failures++;
      $display("[TB] FAIL %s_busyModel: busy got %b expected %b", n, bus.busy, anyPending);
    end
  endtask

  // Advances the shadow scoreboard across one edge using only the record.
  task automatic modelEdge(input vec_t v);
    logic issue;
    logic inc;
    logic dec;
    int   rdI;
    int   wbI;
    rdI   = int'(v.rd);
    wbI   = int'(v.wbRd);
    issue = v.valid & ~v.expOut[4] & ~v.br;
    inc   = issue & v.rdEn & ~v.isHalt & (rdI != 0);
    dec   = v.wbEn & (wbI != 0);
    if (inc && !(dec && wbI == rdI)) begin
      assert (shadow[rdI] < 3) else begin
        failures++;
        $error("[TB] FAIL protocolOverflow: r%0d count %0d required below 3", rdI, shadow[rdI]);
      end
      if (shadow[rdI] < 3) shadow[rdI]++;
    end
    if (dec && !(inc && wbI == rdI)) begin
      assert (shadow[wbI] > 0) else begin
        failures++;
        $error("[TB] FAIL protocolUnderflow: r%0d count %0d required above 0", wbI, shadow[wbI]);
      end
      if (shadow[wbI] > 0) shadow[wbI]--;
    end
  endtask

  task automatic clearShadow();
    foreach (shadow[k]) shadow[k] = 0;
  endtask

  // One full cycle: drive, sample mid-cycle, update model, cross the edge.
  task automatic runVec(input vec_t v);
    applyStimulus(v);
    #3;
    checkOutput();
    checkBusyModel(v.name);
    modelEdge(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    clearShadow();

    //          name                 v  r1 e  r2 e  rd e  h  br wb e  expected
    tbl[0]  = mk("rawIssueR5",       1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 5'b00000);
    tbl[1]  = mk("rawStall1",        1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001);
    tbl[2]  = mk("rawStall2",        1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001);
    tbl[3]  = mk("rawStall3Wb",      1, 5, 1, 0, 0, 0, 0, 0, 0, 5, 1, 5'b11001);
    tbl[4]  = mk("rawReaderIssues",  1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[5]  = mk("dblIssue1",        1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 5'b00000);
    tbl[6]  = mk("dblIssue2",        1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 5'b00001);
    tbl[7]  = mk("dblStallWb1",      1, 0, 0, 7, 1, 0, 0, 0, 0, 7, 1, 5'b11001);
    tbl[8]  = mk("dblStallWb2",      1, 0, 0, 7, 1, 0, 0, 0, 0, 7, 1, 5'b11001);
    tbl[9]  = mk("dblReaderIssues",  1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[10] = mk("simIssueR3",       1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 5'b00000);
    tbl[11] = mk("simSetClear",      1, 0, 0, 0, 0, 3, 1, 0, 0, 3, 1, 5'b00001);
    tbl[12] = mk("simReaderStallWb", 1, 3, 1, 0, 0, 0, 0, 0, 0, 3, 1, 5'b11001);
    tbl[13] = mk("simReaderIssues",  1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[14] = mk("brIssueR2",        1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 5'b00000);
    tbl[15] = mk("brOverStall",      1, 2, 1, 0, 0, 9, 1, 0, 1, 0, 0, 5'b01101);
    tbl[16] = mk("brThenStallWb",    1, 2, 1, 0, 0, 9, 1, 0, 0, 2, 1, 5'b11001);
    tbl[17] = mk("brNoCount",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[18] = mk("r0Issue",          1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[19] = mk("r0ReadNoStall",    1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000);

    // Reset held with hostile inputs, across a clock edge.
    rst_n = 1'b0;
    applyStimulus(mk("resetHold", 1, 2, 1, 3, 1, 4, 1, 1, 1, 3, 1, 5'b00000));
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    applyStimulus(mk("resetHoldEdge", 1, 2, 1, 3, 1, 4, 1, 1, 1, 3, 1, 5'b00000));
    #1;
    checkOutput();
    rst_n = 1'b1;
    $display("[TB] reset released, running vector table");

    for (int i = 0; i < 20; i++) begin
      runVec(tbl[i]);
    end

    $display("[TB] halt drain sequence");
    runVec(mk("haltIssueR4",     1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 5'b00000));
    runVec(mk("haltIssue",       1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 5'b00001));
    runVec(mk("drainBrIgnored",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11001));
    runVec(mk("drainWbR4",       0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 5'b11001));
    runVec(mk("drainWait1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    runVec(mk("drainWait2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    runVec(mk("haltedReached",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11010));

    for (int i = 0; i < 20; i++) begin
      v = mk("haltedHold", 1'($urandom_range(1)), int'($urandom_range(31)), 1'($urandom_range(1)),
             int'($urandom_range(31)), 1'($urandom_range(1)), int'($urandom_range(31)),
             1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0, 5'b11010);
      runVec(v);
    end

    $display("[TB] reset out of HALTED");
    applyStimulus(mk("resetFromHalted", 1, 1, 1, 2, 1, 3, 1, 1, 1, 5, 1, 5'b00000));
    rst_n = 1'b0;
    #1;
    checkOutput();
    clearShadow();
    #1;
    rst_n = 1'b1;

    runVec(mk("postResetIssueR6", 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 5'b00000));
    runVec(mk("haltIssue2",       1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001));

    $display("[TB] reset in the middle of DRAIN");
    applyStimulus(mk("drainBeforeReset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11001));
    #3;
    checkOutput();
    checkBusyModel("drainBeforeReset");
    rst_n = 1'b0;
    applyStimulus(mk("resetMidDrain",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000));
    #1;
    checkOutput();
    clearShadow();
    #1;
    rst_n = 1'b1;

    runVec(mk("issueR1AfterReset", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 5'b00000));
    runVec(mk("busyAfterR1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001));
    runVec(mk("wbR1",              0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00001));
    runVec(mk("r6NotPending",      1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
